// File: rtl/stream_narrow_pkg.sv
// Shared sizing helpers and the narrow-beat record for stream_narrow.
package stream_narrow_pkg;

    function automatic int out_bytes(input int in_bytes, input int ratio);
        return in_bytes / ratio;
    endfunction

    // Chunk index width; never below one bit so RATIO==1 still has an index.
    function automatic int idx_width(input int ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

    localparam int DEF_IN_BYTES   = 8;
    localparam int DEF_RATIO      = 4;
    localparam int DEF_DEST_WIDTH = 4;
    localparam int DEF_OUT_BYTES  = out_bytes(DEF_IN_BYTES, DEF_RATIO);

    typedef struct packed {
        logic [8*DEF_OUT_BYTES-1:0] data;
        logic [DEF_OUT_BYTES-1:0]   keep;
        logic [DEF_DEST_WIDTH-1:0]  dest;
        logic                       last;
    } chunk_t;

endpackage

// File: rtl/stream_narrow_lastidx.sv
// Highest non-empty chunk finder over a wide TKEEP; all-zero keep maps to chunk 0.
module stream_narrow_lastidx
    import stream_narrow_pkg::*;
#(
    parameter int IN_BYTES = 8,
    parameter int RATIO    = 4
) (
    input  logic [IN_BYTES-1:0]         keep_i,
    output logic [idx_width(RATIO)-1:0] last_idx_o
);
    localparam int OB = out_bytes(IN_BYTES, RATIO);
    localparam int IW = idx_width(RATIO);

    logic [RATIO-1:0][OB-1:0] chunks;
    assign chunks = keep_i;

    always_comb begin
        last_idx_o = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (|chunks[i]) last_idx_o = IW'(i);
        end
    end
endmodule

// File: rtl/stream_narrow.sv
// Wide-to-narrow AXI-Stream converter, lowest bytes first, one wide beat of storage.
// Optional STREAM_NARROW_SKIP_EMPTY_EN drops trailing all-zero-keep chunks.
module stream_narrow
    import stream_narrow_pkg::*;
#(
    parameter int IN_BYTES   = 8,
    parameter int RATIO      = 4,
    parameter int DEST_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [8*IN_BYTES-1:0]              in_TDATA,
    input  logic [IN_BYTES-1:0]                in_TKEEP,
    input  logic [DEST_WIDTH-1:0]              in_TDEST,
    input  logic                               in_TLAST,
    input  logic                               in_TVALID,
    output logic                               in_TREADY,
    output logic [8*out_bytes(IN_BYTES,RATIO)-1:0] out_TDATA,
    output logic [out_bytes(IN_BYTES,RATIO)-1:0]   out_TKEEP,
    output logic [DEST_WIDTH-1:0]              out_TDEST,
    output logic                               out_TLAST,
    output logic                               out_TVALID,
    input  logic                               out_TREADY
);
    localparam int OB = out_bytes(IN_BYTES, RATIO);
    localparam int CW = 8 * OB;
    localparam int IW = idx_width(RATIO);

    typedef struct packed {
        logic [8*IN_BYTES-1:0] data;
        logic [IN_BYTES-1:0]   keep;
        logic [DEST_WIDTH-1:0] dest;
        logic                  last;
    } hold_t;

    hold_t          hold_q, hold_d;
    logic           full_q, full_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  last_idx_q, last_idx_d;
    logic [IW-1:0]  load_last_idx;

    logic [RATIO-1:0][CW-1:0] data_chunks;
    logic [RATIO-1:0][OB-1:0] keep_chunks;
    logic at_last, out_acc, retire, in_acc;

`ifdef STREAM_NARROW_SKIP_EMPTY_EN
    stream_narrow_lastidx #(
        .IN_BYTES (IN_BYTES),
        .RATIO    (RATIO)
    ) u_lastidx (
        .keep_i     (in_TKEEP),
        .last_idx_o (load_last_idx)
    );
`else
    assign load_last_idx = IW'(RATIO - 1);
`endif

    assign data_chunks = hold_q.data;
    assign keep_chunks = hold_q.keep;

    assign at_last = (idx_q == last_idx_q);
    assign out_acc = full_q && out_TREADY;
    assign retire  = out_acc && at_last;
    // Retiring the final chunk frees the holder in the same cycle, so a new beat loads without a bubble.
    assign in_TREADY = !rst && (!full_q || retire);
    assign in_acc    = in_TVALID && in_TREADY;

    assign out_TVALID = full_q;
    assign out_TDATA  = data_chunks[idx_q];
    assign out_TKEEP  = keep_chunks[idx_q];
    assign out_TDEST  = hold_q.dest;
    assign out_TLAST  = hold_q.last && at_last;

    always_comb begin
        hold_d     = hold_q;
        full_d     = full_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        if (out_acc) begin
            if (!at_last) idx_d = idx_q + 1'b1;
            else          full_d = 1'b0;
        end
        if (in_acc) begin
            hold_d.data = in_TDATA;
            hold_d.keep = in_TKEEP;
            hold_d.dest = in_TDEST;
            hold_d.last = in_TLAST;
            full_d      = 1'b1;
            idx_d       = '0;
            last_idx_d  = load_last_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            full_q     <= 1'b0;
            idx_q      <= '0;
            last_idx_q <= IW'(RATIO - 1);
        end else begin
            hold_q     <= hold_d;
            full_q     <= full_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
        end
    end
endmodule

// File: tb/tb_stream_narrow.sv
// Directed bench for stream_narrow with a queue model of the expected narrow beats.
module tb_stream_narrow;
    import stream_narrow_pkg::*;

    localparam int IB = 8;
    localparam int R  = 4;
    localparam int OB = 2;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   in_TDATA = '0;
    logic [7:0]    in_TKEEP = '0;
    logic [3:0]    in_TDEST = '0;
    logic          in_TLAST = 1'b0;
    logic          in_TVALID = 1'b0;
    logic          in_TREADY;
    logic [15:0]   out_TDATA;
    logic [1:0]    out_TKEEP;
    logic [3:0]    out_TDEST;
    logic          out_TLAST;
    logic          out_TVALID;
    logic          out_TREADY = 1'b0;

    stream_narrow #(.IN_BYTES(IB), .RATIO(R), .DEST_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP), .in_TDEST(in_TDEST),
        .in_TLAST(in_TLAST), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
        .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP), .out_TDEST(out_TDEST),
        .out_TLAST(out_TLAST), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int pops    = 0;
    chunk_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of narrow beats a wide beat must produce.
    function automatic int n_chunks(input logic [7:0] keep);
        int n;
`ifdef STREAM_NARROW_SKIP_EMPTY_EN
        n = 1;
        for (int k = 0; k < R; k++) if (((keep >> (OB*k)) & 8'h3) != 0) n = k + 1;
`else
        n = R;
`endif
        return n;
    endfunction

    // Model update at each edge: consumer pops the head, producer pushes expanded chunks.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_TVALID && out_TREADY && q.size() > 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (in_TVALID && in_TREADY) begin
                int n;
                n = n_chunks(in_TKEEP);
                for (int k = 0; k < n; k++) begin
                    chunk_t c;
                    c.data = 16'((in_TDATA >> (16*k)) & 64'hFFFF);
                    c.keep = 2'((in_TKEEP >> (2*k)) & 8'h3);
                    c.dest = in_TDEST;
                    c.last = in_TLAST && (k == n - 1);
                    q.push_back(c);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = !rst && (q.size() == 0 || (q.size() == 1 && out_TREADY));
        check("in_TREADY", {63'd0, in_TREADY}, {63'd0, exp_rdy});
        check("out_TVALID", {63'd0, out_TVALID}, {63'd0, q.size() != 0});
        if (q.size() != 0 && out_TVALID) begin
            check("out_TDATA", {48'd0, out_TDATA}, {48'd0, q[0].data});
            check("out_TKEEP", {62'd0, out_TKEEP}, {62'd0, q[0].keep});
            check("out_TDEST", {60'd0, out_TDEST}, {60'd0, q[0].dest});
            check("out_TLAST", {63'd0, out_TLAST}, {63'd0, q[0].last});
        end
    end

    // Presents a beat and returns after the accepting edge; valid is left high.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [3:0] dest,
                        input logic l, output int waits);
        logic acc;
        in_TDATA = d; in_TKEEP = k; in_TDEST = dest; in_TLAST = l; in_TVALID = 1'b1;
        waits = 0;
        acc = 1'b0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = in_TREADY;
            waits++;
            @(posedge clk); #1;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int budget);
        int c;
        in_TVALID = 1'b0;
        c = 0;
        while (q.size() != 0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (q.size() != 0) check("drain_timeout", 64'd0, 64'd1);
    endtask

    logic [15:0] exp1 [4];
    initial begin
        int w, p0;
        exp1[0] = 16'h2211; exp1[1] = 16'h4433; exp1[2] = 16'h6655; exp1[3] = 16'h8877;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {63'd0, in_TREADY}, 64'd1);
        check("post_reset_valid", {63'd0, out_TVALID}, 64'd0);
        check("post_reset_data", {48'd0, out_TDATA}, 64'd0);
        @(posedge clk); #1;

        // Basic beat with literal chunk values.
        out_TREADY = 1'b1;
        send(64'h8877665544332211, 8'hFF, 4'h5, 1'b1, w);
        in_TVALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("basic_data", {48'd0, out_TDATA}, {48'd0, exp1[k]});
            check("basic_last", {63'd0, out_TLAST}, {63'd0, k == 3});
            check("basic_keep", {62'd0, out_TKEEP}, 64'd3);
        end
        drain(20);

        // Back-to-back wide beats; the 2nd and 3rd wait exactly four cycles each.
        send(64'h0102030405060708, 8'hFF, 4'h1, 1'b0, w);
        send(64'h1112131415161718, 8'hFF, 4'h2, 1'b0, w);
        check("b2b_wait2", 64'(w), 64'd4);
        send(64'h2122232425262728, 8'hFF, 4'h3, 1'b1, w);
        check("b2b_wait3", 64'(w), 64'd4);
        drain(20);

        // Backpressure 1,0,0,1 with a second beat waiting.
        out_TREADY = 1'b0;
        p0 = pops;
        send(64'hA1A2A3A4A5A6A7A8, 8'hFF, 4'h7, 1'b1, w);
        in_TDATA = 64'hB1B2B3B4B5B6B7B8; in_TDEST = 4'h9; in_TLAST = 1'b0;
        for (int i = 0; i < 24; i++) begin
            logic acc;
            out_TREADY = (i % 4 == 0) || (i % 4 == 3);
            @(negedge clk);
            acc = in_TVALID && in_TREADY;
            @(posedge clk); #1;
            if (acc) in_TVALID = 1'b0;
        end
        out_TREADY = 1'b1;
        drain(20);
        check("bp_pops", 64'(pops - p0), 64'd8);

        // Partial keep and empty keep.
        p0 = pops;
        send(64'h00000000DDCCBBAA, 8'h0F, 4'h4, 1'b1, w);
        drain(20);
`ifdef STREAM_NARROW_SKIP_EMPTY_EN
        check("partial_beats", 64'(pops - p0), 64'd2);
`else
        check("partial_beats", 64'(pops - p0), 64'd4);
`endif
        p0 = pops;
        send(64'h1234, 8'h00, 4'h6, 1'b1, w);
        drain(20);
`ifdef STREAM_NARROW_SKIP_EMPTY_EN
        check("empty_beats", 64'(pops - p0), 64'd1);
`else
        check("empty_beats", 64'(pops - p0), 64'd4);
`endif

        // Reset after chunk 1 is accepted.
        send(64'hCAFEBABE12345678, 8'hFF, 4'h3, 1'b1, w);
        in_TVALID = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {63'd0, out_TVALID}, 64'd0);
        @(posedge clk); #1;
        send(64'h0000000000009ABC, 8'hFF, 4'hA, 1'b1, w);
        in_TVALID = 1'b0;
        @(negedge clk);
        check("rst_new_dest", {60'd0, out_TDEST}, 64'hA);
        check("rst_new_data", {48'd0, out_TDATA}, 64'h9ABC);
        drain(20);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/stream_narrow.md
# stream_narrow

Width-down converter for the HLS middleware streaming path. It consumes wide beats (TDATA/TKEEP/TDEST/TLAST) from a buffered-handshake stage and emits each one as RATIO narrow beats, lowest bytes first. It is the standard consumer placed after a buffered-handshake register when a wide kernel output feeds a narrow network or bridge port. It holds one wide beat of storage and runs at full narrow-side throughput, with no idle cycle between wide beats.

## Interface
Parameters:
- IN_BYTES, 8, input TDATA width in bytes.
- RATIO, 4, narrow beats per wide beat. IN_BYTES % RATIO == 0 is required; OUT_BYTES = IN_BYTES/RATIO.
- DEST_WIDTH, 4, TDEST width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- in_TDATA  in  8*IN_BYTES  wide data.
- in_TKEEP  in  IN_BYTES  byte enables.
- in_TDEST  in  DEST_WIDTH  destination.
- in_TLAST  in  1  end of packet.
- in_TVALID  in  1  input valid.
- in_TREADY  out  1  input ready.
- out_TDATA  out  8*OUT_BYTES  narrow data.
- out_TKEEP  out  OUT_BYTES  narrow byte enables.
- out_TDEST  out  DEST_WIDTH  copy of the held in_TDEST.
- out_TLAST  out  1  end of packet on the narrow side.
- out_TVALID  out  1  output valid.
- out_TREADY  in  1  output ready.

## Operation
- State is one holding register (data, keep, dest, last), a hold-valid flag `full`, a chunk index `idx` of width clog2(RATIO) (minimum 1), and `last_idx`.
- On an input accept (in_TVALID && in_TREADY):
  - Capture all input fields.
  - Set `full`, `idx`=0.
  - Compute `last_idx`: the index of the final chunk to emit.
- Output fields:
  - out_TDATA = held_data[idx*8*OUT_BYTES +: 8*OUT_BYTES]; out_TKEEP is the corresponding slice of held_keep.
  - out_TVALID = `full`.
  - out_TLAST = held_last && (idx == last_idx).
- On an output accept:
  - If idx != last_idx: idx increments.
  - Else: the wide beat is retired. `full` clears unless a new beat is accepted in the same cycle.
- in_TREADY = !rst && (!full || (out_TVALID && out_TREADY && idx == last_idx)). Load and retire in the same cycle is allowed and gives back-to-back wide beats.
- No combinational path from in_TVALID to out_TVALID. in_TREADY depends combinationally on out_TREADY.
- AXI-Stream rules hold:
  - out_* stay stable while out_TVALID && !out_TREADY.
  - out_TVALID never drops without an accept.
- Wide beats with TKEEP all zero are still emitted (see Configuration for chunk count).

## Timing
- Reset (rst high at a clk edge): full=0, idx=0, last_idx=RATIO-1, holding register cleared to 0.
  - Outputs after reset: out_TVALID=0, out_TLAST=0, out_TDATA/out_TKEEP/out_TDEST=0.
  - in_TREADY=0 while rst is high, 1 in the first cycle after.
- Reset mid-beat discards the held beat and its remaining chunks. No partial TLAST is generated.
- Latency: a beat accepted at edge N presents chunk 0 in the cycle after edge N.
- Throughput: one narrow beat per cycle while out_TREADY is high. A wide beat occupies (last_idx+1) cycles.
- Backpressure: idx holds while out_TREADY is low. in_TREADY stays 0 until the retire cycle.

## Configuration
- Macro: STREAM_NARROW_SKIP_EMPTY_EN.
- Defined: last_idx = the highest chunk index whose TKEEP slice has any bit set. If the whole TKEEP is zero, last_idx = 0. Trailing empty chunks are not emitted, and TLAST moves to chunk last_idx.
- Undefined: last_idx is fixed at RATIO-1. All RATIO chunks are always emitted, including all-zero-keep chunks, and TLAST is on chunk RATIO-1.

## Structure
- Package stream_narrow_pkg holds:
  - the OUT_BYTES derivation function;
  - the clog2-based IDX_WIDTH function (minimum 1);
  - the chunk record typedef (data, keep, dest, last).
- One sub-module: stream_narrow_lastidx. It is combinational and takes the full TKEEP to return last_idx as a highest-set-chunk priority encoder. It is instantiated only when STREAM_NARROW_SKIP_EMPTY_EN is defined.
- Everything else is flat in stream_narrow.

## Test plan
- Reset, defaults (IN_BYTES=8, RATIO=4): after rst release, in_TREADY=1 and out_TVALID=0.
  - Send data 0x8877665544332211, keep 0xFF, last=1, out_TREADY=1.
  - Expect 0x2211, 0x4433, 0x6655, 0x8877 on four consecutive cycles, TLAST only on 0x8877, keep 0x3 each.
- Back-to-back: 3 wide beats with in_TVALID held high and out_TREADY=1.
  - Expect 12 consecutive narrow beats with no bubble.
  - in_TREADY high exactly on cycles 4 and 8 after first load.
- Backpressure: toggle out_TREADY 1,0,0,1,…
  - out_TDATA/out_TKEEP stable during stalls; no chunk dropped or repeated.
  - in_TREADY=0 until the final chunk is accepted.
- Partial keep 0x0F, last=1:
  - Without the macro: 4 beats, keep 3,3,0,0, TLAST on beat 4.
  - With STREAM_NARROW_SKIP_EMPTY_EN: 2 beats, TLAST on beat 2.
  - With the macro and keep 0x00: 1 beat, keep 0.
- Reset mid-beat: assert rst after chunk 1 is accepted.
  - Next cycle: out_TVALID=0.
  - A new beat then emits from chunk 0 with the correct TDEST.
